// File: rtl/dsp48a1_pkg.sv
// Shared widths and OPMODE field encodings for the DSP48A1 slice.
package dsp48a1_pkg;

  localparam int unsigned AB_W = 18;
  localparam int unsigned M_W  = 36;
  localparam int unsigned P_W  = 48;
  localparam int unsigned OP_W = 8;

  // OPMODE bit positions
  localparam int unsigned OP_X_LSB    = 0;
  localparam int unsigned OP_Z_LSB    = 2;
  localparam int unsigned OP_B1_PRE   = 4;
  localparam int unsigned OP_CIN      = 5;
  localparam int unsigned OP_PRE_SUB  = 6;
  localparam int unsigned OP_POST_SUB = 7;

  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

endpackage

// File: rtl/dsp48a1_pipe_reg.sv
// One optionally-bypassed pipeline stage with clock enable and async reset.
module dsp48a1_pipe_reg #(
  parameter int unsigned WIDTH = 18,
  parameter bit          REG   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (REG) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (ce) q <= d;
      end
    end else begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp48a1_slice.sv
// DSP48A1-style slice: pre-adder, 18x18 multiplier, X/Z muxes and 48-bit post-adder.
// Define DSP48A1_PCIN_CASCADE_EN to let Z code 1 select PCIN (otherwise it yields zero).
module dsp48a1_slice
  import dsp48a1_pkg::*;
#(
  parameter int unsigned A0REG       = 0,
  parameter int unsigned A1REG       = 1,
  parameter int unsigned B0REG       = 0,
  parameter int unsigned B1REG       = 1,
  parameter int unsigned CREG        = 1,
  parameter int unsigned DREG        = 1,
  parameter int unsigned MREG        = 1,
  parameter int unsigned PREG        = 1,
  parameter int unsigned CARRYINREG  = 1,
  parameter int unsigned CARRYOUTREG = 1,
  parameter int unsigned OPMODEREG   = 1,
  parameter string       CARRYINSEL  = "OPMODE5",
  parameter string       B_INPUT     = "DIRECT"
) (
  input  logic            clk,
  input  logic            RSTA,
  input  logic            RSTB,
  input  logic            RSTM,
  input  logic            RSTP,
  input  logic            RSTC,
  input  logic            RSTD,
  input  logic            RSTCARRYIN,
  input  logic            RSTOPMODE,
  input  logic            CEA,
  input  logic            CEB,
  input  logic            CEM,
  input  logic            CEP,
  input  logic            CEC,
  input  logic            CED,
  input  logic            CECARRYIN,
  input  logic            CEOPMODE,
  input  logic [AB_W-1:0] A,
  input  logic [AB_W-1:0] B,
  input  logic [AB_W-1:0] D,
  input  logic [AB_W-1:0] BCIN,
  input  logic [P_W-1:0]  C,
  input  logic [P_W-1:0]  PCIN,
  input  logic [OP_W-1:0] OPMODE,
  input  logic            CARRYIN,
  output logic [AB_W-1:0] BCOUT,
  output logic [M_W-1:0]  M,
  output logic [P_W-1:0]  P,
  output logic [P_W-1:0]  PCOUT,
  output logic            CARRYOUT,
  output logic            CARRYOUTF
);

  localparam bit CIN_EXT = (CARRYINSEL == "CARRYIN");
  localparam bit B_CASC  = (B_INPUT == "CASCADE");

  logic [AB_W-1:0] b_src, d_q, b0_q, a0_q, pre_sum, b1_d, b1_q, a1_q;
  logic [OP_W-1:0] op_q;
  logic [M_W-1:0]  m_d, m_q;
  logic [P_W-1:0]  c_q, x_mux, z_mux, p_q;
  logic [P_W:0]    post_sum;
  logic            cyi_d, cyi_q, cyo_q;

  assign b_src = B_CASC ? BCIN : B;

  dsp48a1_pipe_reg #(.WIDTH(AB_W), .REG(DREG != 0)) u_dreg (
    .clk(clk), .rst(RSTD), .ce(CED), .d(D), .q(d_q));
  dsp48a1_pipe_reg #(.WIDTH(AB_W), .REG(B0REG != 0)) u_b0reg (
    .clk(clk), .rst(RSTB), .ce(CEB), .d(b_src), .q(b0_q));
  dsp48a1_pipe_reg #(.WIDTH(AB_W), .REG(A0REG != 0)) u_a0reg (
    .clk(clk), .rst(RSTA), .ce(CEA), .d(A), .q(a0_q));
  dsp48a1_pipe_reg #(.WIDTH(P_W), .REG(CREG != 0)) u_creg (
    .clk(clk), .rst(RSTC), .ce(CEC), .d(C), .q(c_q));
  dsp48a1_pipe_reg #(.WIDTH(OP_W), .REG(OPMODEREG != 0)) u_opreg (
    .clk(clk), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op_q));

  // Pre-adder and B1 source select
  always_comb begin
    pre_sum = op_q[OP_PRE_SUB] ? (d_q - b0_q) : (d_q + b0_q);
    b1_d    = op_q[OP_B1_PRE] ? pre_sum : b0_q;
  end

  dsp48a1_pipe_reg #(.WIDTH(AB_W), .REG(B1REG != 0)) u_b1reg (
    .clk(clk), .rst(RSTB), .ce(CEB), .d(b1_d), .q(b1_q));
  dsp48a1_pipe_reg #(.WIDTH(AB_W), .REG(A1REG != 0)) u_a1reg (
    .clk(clk), .rst(RSTA), .ce(CEA), .d(a0_q), .q(a1_q));

  assign m_d = M_W'(a1_q) * M_W'(b1_q);

  dsp48a1_pipe_reg #(.WIDTH(M_W), .REG(MREG != 0)) u_mreg (
    .clk(clk), .rst(RSTM), .ce(CEM), .d(m_d), .q(m_q));

  assign cyi_d = CIN_EXT ? CARRYIN : op_q[OP_CIN];

  dsp48a1_pipe_reg #(.WIDTH(1), .REG(CARRYINREG != 0)) u_cyireg (
    .clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cyi_d), .q(cyi_q));

  // X/Z operand selection and 49-bit post-adder; P feedback uses the registered P
  always_comb begin
    x_mux = '0;
    z_mux = '0;
    unique case (op_q[OP_X_LSB +: 2])
      X_ZERO:  x_mux = '0;
      X_M:     x_mux = P_W'(m_q);
      X_P:     x_mux = p_q;
      default: x_mux = {d_q[11:0], a1_q, b1_q};
    endcase
    unique case (op_q[OP_Z_LSB +: 2])
      Z_ZERO:  z_mux = '0;
      Z_PCIN: begin
`ifdef DSP48A1_PCIN_CASCADE_EN
        z_mux = PCIN;
`else
        z_mux = '0;
`endif
      end
      Z_P:     z_mux = p_q;
      default: z_mux = c_q;
    endcase
    if (op_q[OP_POST_SUB])
      post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + (P_W+1)'(cyi_q));
    else
      post_sum = {1'b0, z_mux} + {1'b0, x_mux} + (P_W+1)'(cyi_q);
  end

`ifndef DSP48A1_PCIN_CASCADE_EN
  logic unused_pcin;
  assign unused_pcin = ^PCIN;
`endif

  dsp48a1_pipe_reg #(.WIDTH(P_W), .REG(PREG != 0)) u_preg (
    .clk(clk), .rst(RSTP), .ce(CEP), .d(post_sum[P_W-1:0]), .q(p_q));
  dsp48a1_pipe_reg #(.WIDTH(1), .REG(CARRYOUTREG != 0)) u_cyoreg (
    .clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(post_sum[P_W]), .q(cyo_q));

  assign BCOUT     = b1_q;
  assign M         = m_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign CARRYOUT  = cyo_q;
  assign CARRYOUTF = cyo_q;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench for dsp48a1_slice: directed cases plus randomized settled transactions.
module tb_dsp48a1_slice;

  logic clk = 1'b0;
  logic RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE;
  logic CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic [7:0]  OPMODE;
  logic        CARRYIN;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  always #5 clk = ~clk;

  dsp48a1_slice dut (
    .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTM(RSTM), .RSTP(RSTP), .RSTC(RSTC),
    .RSTD(RSTD), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEM(CEM), .CEP(CEP), .CEC(CEC), .CED(CED),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
    .CARRYIN(CARRYIN), .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF));

  typedef struct {
    string       name;
    logic [17:0] bcout;
    logic [35:0] m;
    logic [47:0] p;
    logic        co;
  } exp_t;

  exp_t q[$];
  logic strobe = 1'b0;
  int   total  = 0;
  int   passed = 0;

  function automatic void chk(string name, logic [47:0] act, logic [47:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: compare every presented output against the oldest expectation
  always @(negedge clk) begin
    if (strobe) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 48'd1, 48'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, ".BCOUT"},     48'(BCOUT),     48'(e.bcout));
        chk({e.name, ".M"},         48'(M),         48'(e.m));
        chk({e.name, ".P"},         P,              e.p);
        chk({e.name, ".PCOUT"},     PCOUT,          e.p);
        chk({e.name, ".CARRYOUT"},  48'(CARRYOUT),  48'(e.co));
        chk({e.name, ".CARRYOUTF"}, 48'(CARRYOUTF), 48'(e.co));
      end
    end
  end

  // Reference model of a settled transaction, straight from the arithmetic rules
  function automatic exp_t model(string name, logic [17:0] a, logic [17:0] b,
                                 logic [17:0] d, logic [47:0] c, logic [47:0] pcin,
                                 logic [7:0] op);
    exp_t e;
    logic [17:0] b1;
    logic [47:0] x, z;
    logic [48:0] s;
    b1 = b;
    if (op[4]) b1 = op[6] ? 18'(d - b) : 18'(d + b);
    e.name  = name;
    e.bcout = b1;
    e.m     = 36'(a) * 36'(b1);
    case (op[1:0])
      2'd0: x = 48'd0;
      2'd1: x = 48'(e.m);
      default: x = {d[11:0], a, b1};
    endcase
    case (op[3:2])
      2'd0: z = 48'd0;
`ifdef DSP48A1_PCIN_CASCADE_EN
      2'd1: z = pcin;
`else
      2'd1: z = 48'd0;
`endif
      default: z = c;
    endcase
    if (op[7]) s = 49'(z) - (49'(x) + 49'(op[5]));
    else       s = 49'(z) + 49'(x) + 49'(op[5]);
    e.p  = s[47:0];
    e.co = s[48];
    return e;
  endfunction

  function automatic exp_t mk(string name, logic [17:0] bc, logic [35:0] m,
                              logic [47:0] p, logic co);
    exp_t e;
    e.name = name; e.bcout = bc; e.m = m; e.p = p; e.co = co;
    return e;
  endfunction

  task automatic set_rst(input logic v);
    RSTA = v; RSTB = v; RSTM = v; RSTP = v; RSTC = v; RSTD = v;
    RSTCARRYIN = v; RSTOPMODE = v;
  endtask

  task automatic set_ce(input logic v);
    CEA = v; CEB = v; CEM = v; CEP = v; CEC = v; CED = v;
    CECARRYIN = v; CEOPMODE = v;
  endtask

  task automatic apply(input logic [17:0] a_i, input logic [17:0] b_i,
                       input logic [17:0] d_i, input logic [47:0] c_i,
                       input logic [7:0] op_i);
    A = a_i; B = b_i; D = d_i; C = c_i; OPMODE = op_i;
    BCIN = 18'($urandom); PCIN = {16'($urandom), 32'($urandom)}; CARRYIN = 1'($urandom);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input exp_t e);
    q.push_back(e);
    strobe = 1'b1;
    @(negedge clk);
    #1 strobe = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] op;
    logic [1:0] xs, zs;
    logic [17:0] ra, rb, rd;
    logic [47:0] rc;

    set_ce(1'b1);
    set_rst(1'b1);
    apply(18'h3ABCD, 18'h12345, 18'h2F00F, 48'hDEAD_BEEF_0001, 8'hAD);
    edges(3);
    expect_now(mk("reset", 18'd0, 36'd0, 48'd0, 1'b0));
    set_rst(1'b0);

    // Latency from a clean pipeline: M after 2 clocks, P after 3
    apply(18'd3, 18'd5, 18'd0, 48'd0, 8'h01);
    edges(1); expect_now(mk("lat_clk1", 18'd5, 36'd0, 48'd0, 1'b0));
    edges(1); expect_now(mk("lat_clk2", 18'd5, 36'd15, 48'd0, 1'b0));
    edges(1); expect_now(mk("lat_clk3", 18'd5, 36'd15, 48'd15, 1'b0));

    apply(18'd2, 18'd30, 18'd100, 48'd0, 8'h51);
    edges(5); expect_now(mk("preadd_sub", 18'd70, 36'd140, 48'd140, 1'b0));

    apply(18'd0, 18'd0, 18'd0, 48'd1000, 8'h2C);
    edges(5); expect_now(mk("c_plus_cin", 18'd0, 36'd0, 48'd1001, 1'b0));

    apply(18'd2, 18'd10, 18'd0, 48'd50, 8'h8D);
    edges(5); expect_now(mk("post_sub", 18'd10, 36'd20, 48'd30, 1'b0));

    apply(18'd0, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 8'h2C);
    edges(5); expect_now(mk("carry_wrap", 18'd0, 36'd0, 48'd0, 1'b1));
    CEP = 1'b0;
    apply(18'd0, 18'd0, 18'd0, 48'd5, 8'h2C);
    edges(5); expect_now(mk("cep_hold", 18'd0, 36'd0, 48'd0, 1'b0));
    CEP = 1'b1;

    // M holds with CEM low while A changes
    apply(18'd4, 18'd5, 18'd0, 48'd0, 8'h01);
    edges(5); expect_now(mk("cem_pre", 18'd5, 36'd20, 48'd20, 1'b0));
    CEM = 1'b0;
    apply(18'd9, 18'd5, 18'd0, 48'd0, 8'h01);
    edges(5); expect_now(mk("cem_hold", 18'd5, 36'd20, 48'd20, 1'b0));
    CEM = 1'b1;

    // Accumulate: P <= P + M each clock once Z selects P
    apply(18'd7, 18'd6, 18'd0, 48'd0, 8'h01);
    edges(5); expect_now(mk("acc_base", 18'd6, 36'd42, 48'd42, 1'b0));
    OPMODE = 8'h09;
    edges(3); expect_now(mk("acc_3", 18'd6, 36'd42, 48'd126, 1'b0));
    edges(1); expect_now(mk("acc_4", 18'd6, 36'd42, 48'd168, 1'b0));

    // Random settled transactions (X/Z never select P)
    for (int i = 0; i < 40; i++) begin
      xs = 2'($urandom_range(0, 2)); if (xs == 2'd2) xs = 2'd3;
      zs = 2'($urandom_range(0, 2)); if (zs == 2'd2) zs = 2'd3;
      op = {3'($urandom), 1'($urandom), zs, xs};
      ra = 18'($urandom); rb = 18'($urandom); rd = 18'($urandom);
      rc = {16'($urandom), 32'($urandom)};
      apply(ra, rb, rd, rc, op);
      e = model($sformatf("rand%0d", i), ra, rb, rd, rc, PCIN, op);
      edges(5);
      expect_now(e);
    end

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) chk("drain", 48'(q.size()), 48'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dsp48a1_slice.md
DSP48A1_SLICE -- requirements
Module: dsp48a1_slice

Interface
REQ-001 Parameters SHALL be A0REG=0, A1REG=1, B0REG=0, B1REG=1, CREG=1, DREG=1, MREG=1, PREG=1, CARRYINREG=1, CARRYOUTREG=1, OPMODEREG=1 (1 = stage registered, 0 = stage bypassed combinationally).
REQ-002 Parameter CARRYINSEL default "OPMODE5" SHALL select the carry-in source ("OPMODE5" = OPMODE[5], "CARRYIN" = CARRYIN port).
REQ-003 Parameter B_INPUT default "DIRECT" SHALL select the B source ("DIRECT" = B port, "CASCADE" = BCIN port).
REQ-004 clk  in  1  single rising-edge clock for all registers.
REQ-005 RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE  in  1 each  reset for the A, B, M, P, C, D, carry-in/carry-out and OPMODE registers; reset is asynchronous and active-high.
REQ-006 CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE  in  1 each  clock enable for the matching registers.
REQ-007 A, B, D, BCIN  in  18 each  multiplier, pre-adder and cascade operands.
REQ-008 C, PCIN  in  48 each  post-adder operand and cascade P input.
REQ-009 OPMODE  in  8  operation select; CARRYIN  in  1  external carry.
REQ-010 BCOUT  out  18; M  out  36; P, PCOUT  out  48; CARRYOUT, CARRYOUTF  out  1.

Function
REQ-011 Stage 1: D through DREG, B/BCIN through B0REG, A through A0REG, C through CREG, OPMODE through OPMODEREG.
REQ-012 Pre-adder: OPMODE[6]=0 gives D+B0, OPMODE[6]=1 gives D-B0, result is 18-bit wrap-around.
REQ-013 OPMODE[4]=1 feeds the pre-adder result into B1REG; OPMODE[4]=0 feeds B0 into B1REG; BCOUT SHALL equal the B1 stage output.
REQ-014 A0 output passes through A1REG; multiplier SHALL be unsigned 18x18 A1*B1 giving 36 bits, registered by MREG and driven on M.
REQ-015 X mux (OPMODE[1:0]): 0 = zero, 1 = M zero-extended to 48, 2 = P, 3 = {D[11:0], A1, B1}.
REQ-016 Z mux (OPMODE[3:2]): 0 = zero, 1 = PCIN, 2 = P, 3 = C stage output.
REQ-017 Carry-in SHALL pass through the CYI register (CARRYINREG, CECARRYIN, RSTCARRYIN).
REQ-018 Post-adder: OPMODE[7]=0 gives Z+X+CIN, OPMODE[7]=1 gives Z-(X+CIN), computed at 49 bits; bits [47:0] feed PREG and bit 48 feeds the CYO register.
REQ-019 PCOUT SHALL equal P; CARRYOUTF SHALL equal CARRYOUT.
REQ-020 With default parameters, latency from A/B to M SHALL be 2 clocks and to P 3 clocks, and from C to P 2 clocks, all with OPMODE held constant.
REQ-021 When a register's CE is low, it SHALL hold its value.
REQ-022 P feedback (X=2 or Z=2) SHALL use the current registered P, giving accumulate with no combinational loop when PREG=1.

Reset
REQ-023 Every register SHALL clear to 0 asynchronously while its reset is high, and reset SHALL override CE.
REQ-024 After reset, P, PCOUT, M, BCOUT, CARRYOUT and CARRYOUTF SHALL all read 0.
REQ-025 A bypassed stage (parameter 0) SHALL be unaffected by its reset.

Configuration
REQ-026 Macro DSP48A1_PCIN_CASCADE_EN defined: Z code 1 selects PCIN.
REQ-027 Macro DSP48A1_PCIN_CASCADE_EN undefined: PCIN is ignored and Z code 1 yields zero.

Structure
REQ-028 Package dsp48a1_pkg SHALL hold the width constants (18/36/48) and the OPMODE bit-position, X-code and Z-code constants.
REQ-029 Sub-module dsp48a1_pipe_reg (parameterized width, bypass flag, CE, async reset) SHALL implement every pipeline stage.

Verification
REQ-030 All RST high with nonzero inputs -> P=0, M=0, BCOUT=0, CARRYOUT=0.
REQ-031 A=3, B=5, OPMODE=0x01 -> M=15 after 2 clocks and P=15 after 3 clocks.
REQ-032 D=100, B=30, A=2, OPMODE=0x51 -> BCOUT=70, M=140, P=140.
REQ-033 C=1000, OPMODE=0x2C -> P=1001.
REQ-034 C=50, A=2, B=10, OPMODE=0x8D -> P=30.
REQ-035 C=48'hFFFFFFFFFFFF, OPMODE=0x2C -> P=0, CARRYOUT=1, CARRYOUTF=1; then CEP=0 with a new C -> P held.
